// File: rtl/expr_seq_pkg.sv
// Shared types and constants for the expression-block vector sequencer.
package expr_seq_pkg;

  localparam int unsigned VEC_W_DEF = 60;
  localparam int unsigned RES_W_DEF = 90;
  localparam int unsigned SIG_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EMIT = 2'd2
  } seq_state_e;

  // MISR feedback taps
  localparam int unsigned TAP_A = 31;
  localparam int unsigned TAP_B = 21;
  localparam int unsigned TAP_C = 1;
  localparam int unsigned TAP_D = 0;

endpackage

// File: rtl/expr_seq_misr.sv
// 32-bit MISR: folds each captured result into the running signature.
module expr_seq_misr
  import expr_seq_pkg::*;
#(
  parameter int unsigned      RES_W    = RES_W_DEF,
  parameter logic [SIG_W-1:0] SIG_SEED = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [RES_W-1:0] res_i,
  output logic [SIG_W-1:0] sig_o
);

  logic [SIG_W-1:0] sig_q, sig_d, fold;
  logic             fb;

  // Result is XOR-folded in 32-bit slices; the short top slice is zero-extended.
  always_comb begin
    fold = '0;
    for (int i = 0; i < int'(RES_W); i++) begin
      fold[i % SIG_W] = fold[i % SIG_W] ^ res_i[i];
    end
    fb    = sig_q[TAP_A] ^ sig_q[TAP_B] ^ sig_q[TAP_C] ^ sig_q[TAP_D];
    sig_d = sig_q;
    if (clr_i) begin
      sig_d = SIG_SEED;
    end else if (en_i) begin
      sig_d = {sig_q[SIG_W-2:0], fb} ^ fold;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= SIG_SEED;
    else        sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/expr_vector_sequencer.sv
// Drives operand vectors into a combinational block, waits a settle time,
// captures the result, signs it and hands it out on a valid/ready stream.
//
//   state | meaning
//   IDLE  | ready for a vector; op_vec holds last operands
//   WAIT  | operands settling; capture when counter reads 0
//   EMIT  | out_res valid, held until out_ready
module expr_vector_sequencer
  import expr_seq_pkg::*;
#(
  parameter int unsigned VEC_W    = VEC_W_DEF,
  parameter int unsigned RES_W    = RES_W_DEF,
  parameter int unsigned SETTLE   = 1,
  parameter logic [31:0] SIG_SEED = 32'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_vec,
  output logic [VEC_W-1:0] op_vec,
  input  logic [RES_W-1:0] res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_res,
  input  logic             clear,
  output logic [31:0]      sig,
  output logic [15:0]      vec_count
);

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  seq_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [VEC_W-1:0] op_vec_q, op_vec_d;
  logic [RES_W-1:0] out_res_q, out_res_d;
  logic [15:0]      vec_count_q, vec_count_d;
  logic             capture;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_vec_d  = op_vec_q;
    out_res_d = out_res_q;
    capture   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_vec_d = in_vec;
          cnt_d    = SETTLE_L;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          capture   = 1'b1;
          out_res_d = res;
          state_d   = EMIT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      EMIT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear beats capture: the result is still emitted but not counted.
  always_comb begin
    vec_count_d = vec_count_q;
    if (clear) begin
      vec_count_d = '0;
    end else if (capture && vec_count_q != 16'hFFFF) begin
      vec_count_d = vec_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_vec_q    <= '0;
      out_res_q   <= '0;
      vec_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_vec_q    <= op_vec_d;
      out_res_q   <= out_res_d;
      vec_count_q <= vec_count_d;
    end
  end

  expr_seq_misr #(
    .RES_W    (RES_W),
    .SIG_SEED (SIG_SEED)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (capture),
    .clr_i (clear),
    .res_i (res),
    .sig_o (sig)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign op_vec    = op_vec_q;
  assign out_res   = out_res_q;
  assign vec_count = vec_count_q;

endmodule

// File: tb/tb_expr_vector_sequencer.sv
// Randomized bench for expr_vector_sequencer against a transaction-level model.
module tb_expr_vector_sequencer;

  localparam int          SETTLE = 1;
  localparam logic [31:0] SEED   = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, clear;
  logic [59:0] in_vec, op_vec;
  logic [89:0] res, out_res, salt;
  logic [31:0] sig;
  logic [15:0] vec_count;
  bit          res_mode;

  int          n_vec, n_err, cyc, last_acc, last_hold;
  logic [31:0] m_sig;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  expr_vector_sequencer #(.SETTLE(SETTLE), .SIG_SEED(SEED)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .op_vec    (op_vec),
    .res       (res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .clear     (clear),
    .sig       (sig),
    .vec_count (vec_count)
  );

  // Expression-block stand-in: constant 1, or a salted mix of the operands.
  function automatic logic [89:0] stub_res(input logic [59:0] v, input bit mode, input logic [89:0] s);
    if (!mode) return 90'h1;
    return {v[29:0], v} ^ {v, v[59:30]} ^ s;
  endfunction

  always_comb res = stub_res(op_vec, res_mode, salt);

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [89:0] r);
    logic [31:0] fold;
    logic        fb;
    fold = r[31:0] ^ r[63:32] ^ {6'b0, r[89:64]};
    fb   = s[31] ^ s[21] ^ s[1] ^ s[0];
    return {s[30:0], fb} ^ fold;
  endfunction

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_sig     = SEED;
    m_cnt     = '0;
    last_acc  = -1;
    last_hold = 0;
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_op_vec", op_vec, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_sig", sig, SEED);
    chk("rst_vec_count", vec_count, 0);
  endtask

  // One full transaction: accept, settle, capture, hold in EMIT, handshake.
  task automatic send(input logic [59:0] v, input int hold, input bit clr_cap, input bit poke);
    logic [89:0] er;
    int          n, acc;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    in_vec    = v;
    out_ready = (hold == 0);
    tick();
    acc      = cyc;
    in_valid = 1'b0;
    chk("op_vec_load", op_vec, v);
    chk("busy_after_accept", in_ready, 0);
    if (last_acc >= 0) chk("accept_period", acc - last_acc, SETTLE + 3 + last_hold);
    last_acc  = acc;
    last_hold = hold;
    for (int i = 0; i < SETTLE; i++) begin
      if (poke) begin
        in_valid = 1'b1;
        in_vec   = ~v;
      end
      tick();
      chk("settle_no_valid", out_valid, 0);
      chk("settle_op_hold", op_vec, v);
    end
    in_valid = 1'b0;
    clear    = clr_cap;
    tick();
    clear = 1'b0;
    er    = stub_res(v, res_mode, salt);
    if (clr_cap) begin
      m_sig = SEED;
      m_cnt = '0;
    end else begin
      m_sig = misr_step(m_sig, er);
      if (m_cnt != 16'hFFFF) m_cnt++;
    end
    chk("capture_valid", out_valid, 1);
    chk("capture_res", out_res, er);
    chk("capture_sig", sig, m_sig);
    chk("capture_count", vec_count, m_cnt);
    for (int i = 0; i < hold; i++) begin
      in_valid = poke;
      in_vec   = ~v;
      tick();
      chk("emit_hold_valid", out_valid, 1);
      chk("emit_hold_res", out_res, er);
      chk("emit_hold_ready", in_ready, 0);
      chk("emit_hold_op", op_vec, v);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("emit_exit_valid", out_valid, 0);
    chk("emit_exit_ready", in_ready, 1);
    chk("idle_op_hold", op_vec, v);
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b1; clear = 1'b0;
    res_mode = 1'b0; salt = '0;
    model_reset();
    #23;
    check_reset_vals();
    rst_n = 1'b1;
    tick();
    check_reset_vals();

    // Constant result 1 from seed 0 signs to 1.
    send(60'h123_4567_89AB_CDEF, 0, 1'b0, 1'b0);
    chk("first_sig", sig, 32'h1);

    res_mode = 1'b1;
    salt     = 90'({$urandom, $urandom, $urandom});
    for (int i = 0; i < 4; i++) send(60'({$urandom, $urandom}), 0, 1'b0, 1'b0);
    chk("b2b_count", vec_count, 5);

    send(60'({$urandom, $urandom}), 10, 1'b0, 1'b1);

    send(60'({$urandom, $urandom}), 2, 1'b1, 1'b0);
    chk("clear_cap_sig", sig, SEED);
    chk("clear_cap_count", vec_count, 0);

    send(60'({$urandom, $urandom}), 0, 1'b0, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_reset();
    chk("clear_idle_sig", sig, SEED);
    chk("clear_idle_count", vec_count, 0);

    // Reset while settling: transaction must vanish.
    in_valid = 1'b1;
    in_vec   = 60'({$urandom, $urandom});
    tick();
    in_valid = 1'b0;
    chk("pre_rst_busy", in_ready, 0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_vals();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_no_valid", out_valid, 0);
    end
    send(60'({$urandom, $urandom}), 1, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      salt = 90'({$urandom, $urandom, $urandom});
      send(60'({$urandom, $urandom}), int'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0), bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
